// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer: IDLE -> RUN -> DONE with stall, branch, halt and
// end-of-program handling. Define PC_PERF_CNT_EN to build the cycle/branch perf counters.
module pc_sequencer #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PROG_LEN = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch,
  input  logic [PC_W-1:0]  target,
  input  logic             halt_instr,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] branch_count
);

  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] LastPc  = PC_W'(PROG_LEN - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StIdle: begin
        pc_d = ResetPc;
        if (start) state_d = StRun;
      end
      StRun: begin
        // Stall masks branch and halt; upstream re-presents them afterwards.
        if (!stall) begin
          if (halt_instr) begin
            state_d = StDone;
          end else if (branch) begin
            pc_d = target;
          end else if (pc_q == LastPc) begin
            state_d = StDone;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (start) begin
          state_d = StRun;
          pc_d    = ResetPc;
        end
      end
      default: begin
        state_d = StIdle;
        pc_d    = ResetPc;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= ResetPc;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q == StRun);
  assign done        = (state_q == StDone);

`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] brcnt_q, brcnt_d;
  logic             cnt_clr, br_taken, in_run;

  always_comb begin
    in_run   = (state_q == StRun);
    cnt_clr  = start && ((state_q == StIdle) || (state_q == StDone));
    br_taken = in_run && !stall && !halt_instr && branch;
    cycle_d  = cycle_q;
    brcnt_d  = brcnt_q;
    if (cnt_clr) begin
      cycle_d = '0;
      brcnt_d = '0;
    end else begin
      // Both counters saturate rather than wrap.
      if (in_run && (cycle_q != '1)) cycle_d = cycle_q + 1'b1;
      if (br_taken && (brcnt_q != '1)) brcnt_d = brcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
      brcnt_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      brcnt_q <= brcnt_d;
    end
  end

  assign cycle_count  = cycle_q;
  assign branch_count = brcnt_q;
`else
  assign cycle_count  = '0;
  assign branch_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PROG_LEN=8), assertion-based checks.
module tb_pc_sequencer;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stall;
  logic             branch;
  logic [PC_W-1:0]  target;
  logic             halt_instr;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] branch_count;

  int n_chk  = 0;
  int n_pass = 0;

  pc_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (0),
    .PROG_LEN (8),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch       (branch),
    .target       (target),
    .halt_instr   (halt_instr),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .done         (done),
    .cycle_count  (cycle_count),
    .branch_count (branch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_st(input string tag, input logic [31:0] epc, input logic efv,
                          input logic edone);
    check({tag, "_pc"}, 32'(pc), epc);
    check({tag, "_fv"}, 32'(fetch_valid), 32'(efv));
    check({tag, "_done"}, 32'(done), 32'(edone));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0;
    target = '0; halt_instr = 1'b0;
    #12;
    check_st("reset", 0, 1'b0, 1'b0);
    check("reset_cyc", 32'(cycle_count), 0);
    check("reset_brc", 32'(branch_count), 0);
    reset = 1'b1;
    tick();
    check_st("idle", 0, 1'b0, 1'b0);

    // T2: straight-line run of PROG_LEN=8
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_st($sformatf("run%0d", i), i, 1'b1, 1'b0);
      tick();
    end
    check_st("eop", 7, 1'b0, 1'b1);
`ifdef PC_PERF_CNT_EN
    check("eop_cyc", 32'(cycle_count), 8);
    check("eop_brc", 32'(branch_count), 0);
`endif
    tick();
    check_st("eop_hold", 7, 1'b0, 1'b1);

    // T3: restart from DONE, branch at pc=3
    start = 1'b1;
    tick();
    start = 1'b0;
    check_st("restart", 0, 1'b1, 1'b0);
`ifdef PC_PERF_CNT_EN
    check("restart_cyc", 32'(cycle_count), 0);
`endif
    tick(); tick(); tick();
    check("pre_br_pc", 32'(pc), 3);
    branch = 1'b1; target = 10'h040;
    tick();
    branch = 1'b0;
    check("br_pc", 32'(pc), 32'h40);
    tick();
    check("br_next_pc", 32'(pc), 32'h41);
`ifdef PC_PERF_CNT_EN
    check("br_brc", 32'(branch_count), 1);
    check("br_cyc", 32'(cycle_count), 5);
`endif

    // T4: stall with branch and halt pending at pc=5
    branch = 1'b1; target = 10'd5;
    tick();
    check("to5_pc", 32'(pc), 5);
    stall = 1'b1; branch = 1'b1; target = 10'h100; halt_instr = 1'b1;
    tick();
    check_st("stall1", 5, 1'b1, 1'b0);
    tick();
    check_st("stall2", 5, 1'b1, 1'b0);
    stall = 1'b0; halt_instr = 1'b0;
    tick();
    branch = 1'b0;
    check_st("unstall", 32'h100, 1'b1, 1'b0);
`ifdef PC_PERF_CNT_EN
    check("stall_cyc", 32'(cycle_count), 9);
    check("stall_brc", 32'(branch_count), 3);
`endif

    // Branch at last address is taken
    branch = 1'b1; target = 10'd7;
    tick();
    check("to7_pc", 32'(pc), 7);
    target = 10'h020;
    tick();
    branch = 1'b0;
    check_st("br_at_last", 32'h20, 1'b1, 1'b0);

    // T5: halt at pc=12, then restart
    branch = 1'b1; target = 10'd12;
    tick();
    branch = 1'b0;
    check("to12_pc", 32'(pc), 12);
    halt_instr = 1'b1;
    tick();
    halt_instr = 1'b0;
    check_st("halt", 12, 1'b0, 1'b1);
    tick();
    check_st("halt_hold", 12, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_st("halt_restart", 0, 1'b1, 1'b0);
    tick();
    check("run_pc1", 32'(pc), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_st("start_in_run", 2, 1'b1, 1'b0);

    // T1: asynchronous reset mid-run at pc=37
    branch = 1'b1; target = 10'd37;
    tick();
    branch = 1'b0;
    check("to37_pc", 32'(pc), 37);
    #2;
    reset = 1'b0;
    #1;
    check_st("async_rst", 0, 1'b0, 1'b0);
    check("async_rst_cyc", 32'(cycle_count), 0);
    check("async_rst_brc", 32'(branch_count), 0);
    #3;
    reset = 1'b1;
    tick();
    check_st("post_rst_idle", 0, 1'b0, 1'b0);

    // T6: counter saturation (or constant zero without the perf build)
    start = 1'b1;
    tick();
    start = 1'b0;
    stall = 1'b1;
`ifdef PC_PERF_CNT_EN
    repeat (70000) tick();
    check("sat_cyc", 32'(cycle_count), 32'hFFFF);
    check("sat_brc", 32'(branch_count), 0);
    check_st("sat_state", 0, 1'b1, 1'b0);
`else
    repeat (20) tick();
    check("nocnt_cyc", 32'(cycle_count), 0);
    check("nocnt_brc", 32'(branch_count), 0);
    check_st("nocnt_state", 0, 1'b1, 1'b0);
`endif
    stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
